fetch_unit: RTL

- Parametrised successor to the core's single-cycle fetch stage (PC register, +4 adder, branch-select mux).
- Decouples fetch from an instruction memory that has variable latency, using a valid/ready request channel and an in-order response channel.
- Buffers fetched instructions in a prefetch FIFO that decode drains with valid/ready; decode stall is simply `if_ready=0`.
- Handles branch redirect: flushes the FIFO and discards responses still in flight.

---
 rtl/core_pkg.sv | 16 +
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end.
//   XLEN          : architectural address/data width
//   NOP_INSTR     : instruction word presented to decode when nothing is fetched
//   fetch_entry_t : one prefetch slot, the instruction together with its PC
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, used as the fetch prefetch buffer.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
//   clock, reset : clock and asynchronous active-low reset
//   push/push_data : write one entry (ignored when full unless popping too)
//   pop          : drop the head entry (ignored when empty)
//   flush        : empty the FIFO; wins over push and pop in the same cycle
//   full, empty, count : occupancy status
//   head         : current head entry (undefined content when empty)
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end for a variable-latency instruction memory.
// Requests go out on a valid/ready channel, responses come back in order and
// cannot be stalled. Fetched words land in a prefetch FIFO that decode drains
// with if_valid/if_ready. A redirect flushes the FIFO and marks every fetch
// still in flight as stale so its response is thrown away on arrival.
//   clock, reset        : clock and asynchronous active-low reset
//   redirect_valid/pc   : taken branch/jump target from execute (bits [1:0] ignored)
//   imem_req_*          : fetch request channel (word-aligned address)
//   imem_rsp_*          : in-order response channel
//   if_valid/ready      : handshake to decode; if_pc/if_instr describe the head
module fetch_unit #(
    parameter int              XLEN              = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC          = '0,
    parameter int              FIFO_DEPTH        = 4,
    parameter int              MAX_LATENCY_CHECK = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    import core_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = XLEN + 32;

    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_pop;

    logic [CNT_W:0]  inflight;
    logic            credit;
    logic            req_fire;
    logic            rsp_any;
    logic            rsp_stale;
    logic            rsp_live;
    logic [XLEN-1:0] redirect_tgt;

    // Every live entry plus every fetch still in flight owns a FIFO slot, so a
    // live response always finds room.
    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit   = (inflight < (CNT_W + 1)'(FIFO_DEPTH));

    // Gating with reset keeps the request low while reset is held; the credit
    // term alone would be true because all counters are cleared.
    assign imem_req_valid = credit & ~redirect_valid & reset;
    assign imem_req_addr  = req_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is not ours and is ignored.
    assign rsp_any   = imem_rsp_valid & (outstanding_q != '0);
    assign rsp_stale = rsp_any & (drop_cnt_q != '0);
    assign rsp_live  = rsp_any & (drop_cnt_q == '0) & ~redirect_valid;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);

    assign fifo_pop = if_valid & if_ready;

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_any);
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid) begin
            req_pc_d   = redirect_tgt;
            rsp_pc_d   = redirect_tgt;
            // Whatever remains in flight after this cycle belongs to the old path.
            drop_cnt_d = outstanding_q - CNT_W'(rsp_any);
        end else begin
            if (req_fire) begin
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (rsp_live) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
            end
            if (rsp_stale) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pc_q      <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rsp_live),
        .push_data ({rsp_pc_q, imem_rsp_data}),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Entry layout is {pc, instr}; an empty FIFO presents PC 0 and a NOP.
    assign if_valid = ~fifo_empty;
    assign if_pc    = if_valid ? fifo_head[ENTRY_W-1:32] : '0;
    assign if_instr = if_valid ? fifo_head[31:0] : NOP_INSTR;

    a_live_push_has_room : assert property (
        @(posedge clock) disable iff (!reset) rsp_live |-> !fifo_full
    );

    generate
        if (MAX_LATENCY_CHECK != 0) begin : g_rsp_check
            a_rsp_has_request : assert property (
                @(posedge clock) disable iff (!reset)
                imem_rsp_valid |-> (outstanding_q != '0)
            );
        end
    endgenerate

endmodule
